// File: rtl/dmem_shim_pkg.sv
// rtl/dmem_shim_pkg.sv - shared state encoding, request struct and constants for dmem_wait_shim
package dmem_shim_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STALL  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STALL  = ST_STALL,
    ACCESS = ST_ACCESS,
    DONE   = ST_DONE
  } dmem_state_e;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

  localparam int DMEM_SHIM_MIN_LAT = 2;

endpackage

// File: rtl/dmem_req_stability_check.sv
// rtl/dmem_req_stability_check.sv - flags a core request that drops or changes while the shim holds it
module dmem_req_stability_check
  import dmem_shim_pkg::*;
(
  input  logic      holding,
  input  logic      live_valid,
  input  dmem_req_t live_req,
  input  dmem_req_t held_req,
  output logic      mismatch
);

  assign mismatch = holding && (!live_valid || (live_req != held_req));

endmodule

// File: rtl/dmem_wait_shim.sv
// rtl/dmem_wait_shim.sv - valid/ready wrapper adding bounded wait states in front of an always-ready memory
// Optional fault injection on accepted requests: define DMEM_SHIM_FAULT_EN.
module dmem_wait_shim
  import dmem_shim_pkg::*;
#(
  parameter int MAX_WAIT = 7,
  parameter int WAIT_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_instr,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic [WAIT_W-1:0] wait_req,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
`ifdef DMEM_SHIM_FAULT_EN
  input  logic              fault_req,
  output logic              cpu_fault,
`endif
  output logic              proto_err
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] ONE     = WAIT_W'(1);

  dmem_state_e       state;
  dmem_req_t         req_q;
  dmem_req_t         live_req;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] wait_clamped;
  logic [31:0]       rdata_q;
  logic              fault_q;
  logic              fault_in;
  logic              mismatch;

  assign live_req     = {cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb};
  assign wait_clamped = (wait_req > MAX_CNT) ? MAX_CNT : wait_req;

`ifdef DMEM_SHIM_FAULT_EN
  assign fault_in  = fault_req;
  assign cpu_fault = cpu_ready && fault_q;
`else
  assign fault_in  = 1'b0;
`endif

  // The request is owned by the shim from the cycle after accept until DONE retires it.
  dmem_req_stability_check u_check (
    .holding    (state != IDLE),
    .live_valid (cpu_valid),
    .live_req   (live_req),
    .held_req   (req_q),
    .mismatch   (mismatch)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (mismatch) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cpu_valid) begin
            req_q   <= live_req;
            cnt     <= wait_clamped;
            fault_q <= fault_in;
            state   <= (wait_clamped == '0) ? ACCESS : STALL;
          end
        end
        STALL: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= mem_rdata;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // mem_* always reflect the latch; only mem_valid qualifies them.
  assign mem_valid = (state == ACCESS) && !fault_q;
  assign mem_instr = req_q.instr;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;

  assign cpu_ready = (state == DONE);
  assign cpu_rdata = (cpu_ready && !fault_q) ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_wait_shim.sv
// tb/tb_dmem_wait_shim.sv - scoreboard bench for dmem_wait_shim with a cycle-level reference model
module tb_dmem_wait_shim;

  localparam int MAX_WAIT = 5;
  localparam int WAIT_W   = 3;

  typedef struct {
    int          mem_cyc;
    int          rdy_cyc;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          fault;
  } exp_t;

  logic              clock;
  logic              reset;
  logic              cpu_valid;
  logic              cpu_instr;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic [WAIT_W-1:0] wait_req;
  logic              mem_valid;
  logic              mem_instr;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              proto_err;
`ifdef DMEM_SHIM_FAULT_EN
  logic              fault_req;
  logic              cpu_fault;
  bit                next_fault = 0;
`endif

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   exp_proto = 0;
  exp_t exp_mem_q[$];
  exp_t exp_rdy_q[$];
  exp_t me, re;

  dmem_wait_shim #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .cpu_instr (cpu_instr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .wait_req  (wait_req),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
`ifdef DMEM_SHIM_FAULT_EN
    .fault_req (fault_req),
    .cpu_fault (cpu_fault),
`endif
    .proto_err (proto_err)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a memory strobe or a completion.
  always @(negedge clock) begin
    if (mem_valid === 1'b1) begin
      if (exp_mem_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_mem_valid: got 1 expected 0 (cycle %0d addr %h)", cyc, mem_addr);
      end else begin
        me = exp_mem_q.pop_front();
        chk("mem_cycle", cyc, me.mem_cyc);
        chk("mem_instr", {31'd0, mem_instr}, {31'd0, me.instr});
        chk("mem_addr", mem_addr, me.addr);
        chk("mem_wdata", mem_wdata, me.wdata);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, me.wstrb});
      end
    end
    if (cpu_ready === 1'b1) begin
      if (exp_rdy_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_cpu_ready: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        re = exp_rdy_q.pop_front();
        chk("ready_cycle", cyc, re.rdy_cyc);
        if (re.fault) chk("fault_rdata", cpu_rdata, 32'd0);
        else if (re.wstrb == 4'd0) chk("cpu_rdata", cpu_rdata, re.rdata);
`ifdef DMEM_SHIM_FAULT_EN
        chk("cpu_fault", {31'd0, cpu_fault}, {31'd0, re.fault});
`endif
      end
    end
`ifdef DMEM_SHIM_FAULT_EN
    else if (cpu_ready === 1'b0 && cpu_fault !== 1'b0) begin
      chk("cpu_fault_idle", {31'd0, cpu_fault}, 32'd0);
    end
`endif
  end

  task automatic check_zero(input string tag);
    chk({tag, "_cpu_ready"}, {31'd0, cpu_ready}, 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
    chk({tag, "_mem_instr"}, {31'd0, mem_instr}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, "_proto_err"}, {31'd0, proto_err}, 32'd0);
  endtask

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
  task automatic issue(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int wt, input bit violate);
    exp_t e;
    int   w;
    w = (wt > MAX_WAIT) ? MAX_WAIT : wt;
    cpu_valid = 1'b1;
    cpu_instr = instr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;
    wait_req  = WAIT_W'(wt);
    e.mem_cyc = cyc + 1 + w;
    e.rdy_cyc = cyc + 2 + w;
    e.instr   = instr;
    e.addr    = addr;
    e.wdata   = wdata;
    e.wstrb   = wstrb;
    e.rdata   = mem_model(addr);
    e.fault   = 0;
`ifdef DMEM_SHIM_FAULT_EN
    fault_req = next_fault;
    e.fault   = next_fault;
`endif
    if (!e.fault) exp_mem_q.push_back(e);
    exp_rdy_q.push_back(e);
    @(negedge clock);
    wait_req = WAIT_W'($urandom);
`ifdef DMEM_SHIM_FAULT_EN
    fault_req = 1'($urandom);
`endif
    if (violate && w >= 1) begin
      cpu_addr  = addr + 32'd4;
      exp_proto = 1;
    end
    repeat (w + 2) @(negedge clock);
    chk("proto_err", {31'd0, proto_err}, {31'd0, exp_proto});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; cpu_valid = 0; cpu_instr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0; wait_req = 0;
`ifdef DMEM_SHIM_FAULT_EN
    fault_req = 0;
`endif
    repeat (3) @(negedge clock);
    reset = 0;
    check_zero("reset");

    issue(1'b0, 32'h100, 32'h0, 4'b0000, 0, 0);
    issue(1'b0, 32'h200, 32'h12345678, 4'b0011, 3, 0);
    issue(1'b1, 32'h180, 32'h0, 4'b0000, 7, 0);
    issue(1'b0, 32'h300, 32'h0, 4'b0000, 2, 1);
    chk("mem_addr_after_violation", mem_addr, 32'h300);
    issue(1'b0, 32'h310, 32'h0, 4'b0000, 1, 0);

    // Reset in the second STALL cycle of a wait-4 request: nothing may be emitted for it.
    cpu_valid = 1; cpu_instr = 0; cpu_addr = 32'h400; cpu_wdata = 32'h0; cpu_wstrb = 4'h0; wait_req = 3'd4;
    repeat (2) @(negedge clock);
    reset = 1; cpu_valid = 0;
    @(negedge clock);
    reset = 0; exp_proto = 0;
    check_zero("midreset");
    repeat (8) @(negedge clock);
    issue(1'b0, 32'h440, 32'h0, 4'b0000, 4, 0);

    for (int i = 0; i < 40; i++) begin
      int gap;
      issue(1'($urandom), $urandom, $urandom, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom),
            int'($urandom_range(0, 7)), 0);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        cpu_valid = 0;
        cpu_addr  = $urandom;
        wait_req  = WAIT_W'($urandom);
        repeat (gap) @(negedge clock);
      end
    end

`ifdef DMEM_SHIM_FAULT_EN
    next_fault = 1;
    issue(1'b0, 32'h500, 32'h0, 4'b0000, 1, 0);
    next_fault = 0;
    issue(1'b0, 32'h504, 32'h0, 4'b0000, 0, 0);
`endif

    cpu_valid = 0;
    repeat (12) @(negedge clock);
    chk("drain_mem_q", exp_mem_q.size(), 32'd0);
    chk("drain_rdy_q", exp_rdy_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
